// File: rtl/div_pkg.sv
// Shared state encoding and defaults for the divider job sequencer.
package div_pkg;

    localparam int DIV_WIDTH   = 8;
    localparam int DIV_TIMEOUT = 64;

    // Quotient reported for a zero divisor: all ones at any width.
    localparam logic [DIV_WIDTH-1:0] DIV0_Q = '1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } div_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a fall-through head; full/empty come from a registered count.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/div_job_sequencer.sv
// Buffers operand pairs, issues them one at a time to the divider, and returns results
// on a valid/ready channel with local divide-by-zero handling and a completion timeout.
module div_job_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = DIV_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    output logic [WIDTH-1:0] o_div_a,
    output logic [WIDTH-1:0] o_div_b,
    output logic             o_div_start,
    input  logic             i_div_busy,
    input  logic             i_div_ready,
    input  logic [WIDTH-1:0] i_div_q,
    input  logic [WIDTH-1:0] i_div_r,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_q,
    output logic [WIDTH-1:0] o_out_r,
    output logic             o_out_err,
    output logic [15:0]      o_jobs_done
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC      = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    div_state_t           r_state;
    logic [CW-1:0]        r_tcnt;
    logic [WIDTH-1:0]     r_div_a;
    logic [WIDTH-1:0]     r_div_b;
    logic                 r_div_start;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_q;
    logic [WIDTH-1:0]     r_out_r;
    logic                 r_out_err;
    logic [15:0]          r_jobs_done;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [$clog2(DEPTH):0] w_count_unused;
    logic [2*WIDTH-1:0]   w_fifo_din;
    logic [2*WIDTH-1:0]   w_fifo_dout;
    logic [WIDTH-1:0]     w_head_a;
    logic [WIDTH-1:0]     w_head_b;

    assign o_in_ready = !w_full;
    assign w_push     = i_in_valid && !w_full;
    assign w_pop      = (r_state == IDLE) && !w_empty;
    assign w_fifo_din = {i_in_a, i_in_b};
    assign w_head_a   = w_fifo_dout[2*WIDTH-1:WIDTH];
    assign w_head_b   = w_fifo_dout[WIDTH-1:0];

    sync_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_fifo_din),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count_unused)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_tcnt      <= '0;
            r_div_a     <= '0;
            r_div_b     <= '0;
            r_div_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_q     <= '0;
            r_out_r     <= '0;
            r_out_err   <= 1'b0;
            r_jobs_done <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_div_a <= w_head_a;
                        r_div_b <= w_head_b;
                        // Zero divisor never reaches the divider.
                        if (w_head_b == '0) begin
                            r_out_q     <= {WIDTH{DIV0_Q[0]}};
                            r_out_r     <= w_head_a;
                            r_out_err   <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= HOLD;
                        end else begin
                            r_div_start <= 1'b1;
                            r_state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_div_start <= 1'b0;
                    r_tcnt      <= '0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (i_div_ready && !i_div_busy) begin
                        r_out_q     <= i_div_q;
                        r_out_r     <= i_div_r;
                        r_out_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else if (r_tcnt == TC) begin
                        r_out_q     <= '0;
                        r_out_r     <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else if (r_tcnt != CNT_MAX) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_jobs_done <= r_jobs_done + 16'd1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_div_a     = r_div_a;
    assign o_div_b     = r_div_b;
    assign o_div_start = r_div_start;
    assign o_out_valid = r_out_valid;
    assign o_out_q     = r_out_q;
    assign o_out_r     = r_out_r;
    assign o_out_err   = r_out_err;
    assign o_jobs_done = r_jobs_done;

endmodule

// File: tb/tb_div_job_sequencer.sv
// Scoreboard bench for div_job_sequencer with a behavioural divider model.
module tb_div_job_sequencer;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       err;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] div_a;
    logic [7:0] div_b;
    logic       div_start;
    logic       div_busy  = 1'b0;
    logic       div_ready = 1'b0;
    logic [7:0] div_q     = '0;
    logic [7:0] div_r     = '0;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_q;
    logic [7:0] out_r;
    logic       out_err;
    logic [15:0] jobs_done;

    int   checks   = 0;
    int   failures = 0;
    int   n_start  = 0;
    int   lat      = 4;
    bit   hang     = 1'b0;
    int   m_cnt    = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    div_job_sequencer #(.WIDTH(8), .DEPTH(4), .TIMEOUT(64)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .o_div_a     (div_a),
        .o_div_b     (div_b),
        .o_div_start (div_start),
        .i_div_busy  (div_busy),
        .i_div_ready (div_ready),
        .i_div_q     (div_q),
        .i_div_r     (div_r),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_q     (out_q),
        .o_out_r     (out_r),
        .o_out_err   (out_err),
        .o_jobs_done (jobs_done)
    );

    // Divider model: ready 'lat' cycles after start is seen, never when hung.
    always @(posedge clk) begin
        if (div_start) begin
            div_busy  <= 1'b1;
            div_ready <= 1'b0;
            m_cnt     <= lat;
            div_q     <= (div_b != 0) ? div_a / div_b : 8'h00;
            div_r     <= (div_b != 0) ? div_a % div_b : 8'h00;
        end else if (div_busy && !hang) begin
            if (m_cnt <= 1) begin
                div_busy  <= 1'b0;
                div_ready <= 1'b1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // Monitor: every accepted result is compared against the head of the scoreboard.
    always @(negedge clk) begin
        res_t e;
        if (div_start) n_start++;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result actual q=%0d r=%0d err=%0b required none",
                         out_q, out_r, out_err);
            end else begin
                e = exp_q.pop_front();
                if ({out_q, out_r, out_err} !== e) begin
                    failures++;
                    $display("FAIL result actual q=%0d r=%0d err=%0b required q=%0d r=%0d err=%0b",
                             out_q, out_r, out_err, e.q, e.r, e.err);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ee);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_wait actual=in_ready_low required=accept a=%0d b=%0d", a, b);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(res_t'{q: eq, r: er, err: ee});
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=%0d_pending required=0_pending", name, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int k, input int limit);
        k = 0;
        while (!out_valid && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int s0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_div_start", div_start, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_qr", {out_q, out_r}, 0);
        check("rst_div_ab", {div_a, div_b}, 0);
        check("rst_jobs_done", jobs_done, 0);

        // Single job 14/3
        out_ready = 1'b1;
        lat = 4;
        s0 = n_start;
        push(8'd14, 8'd3, 8'd4, 8'd2, 1'b0);
        check("start_k0", div_start, 0);
        @(posedge clk); #1 check("start_k1", div_start, 1);
        @(posedge clk); #1 check("start_k2", div_start, 0);
        wait_valid(k, 300);
        check("single_valid_latency", k + 2, 7);
        wait_drain("single_drain", 50);
        check("single_start_count", n_start - s0, 1);
        check("jobs_done_1", jobs_done, 1);

        // Divide by zero
        s0 = n_start;
        push(8'd9, 8'd0, 8'hFF, 8'd9, 1'b1);
        wait_valid(k, 300);
        check("div0_valid_latency", k, 1);
        wait_drain("div0_drain", 50);
        repeat (3) @(posedge clk);
        check("div0_no_start", n_start - s0, 0);

        // Timeout: divider never completes
        hang = 1'b1;
        push(8'd50, 8'd5, 8'd0, 8'd0, 1'b1);
        wait_valid(k, 300);
        check("timeout_valid_latency", k, 66);
        wait_drain("timeout_drain", 50);
        hang = 1'b0;
        check("jobs_done_3", jobs_done, 3);

        // FIFO fill under backpressure, then in-order drain
        out_ready = 1'b0;
        lat = 2;
        push(8'd100, 8'd7,  8'd14, 8'd2,  1'b0);
        push(8'd255, 8'd16, 8'd15, 8'd15, 1'b0);
        push(8'd0,   8'd5,  8'd0,  8'd0,  1'b0);
        push(8'd50,  8'd6,  8'd8,  8'd2,  1'b0);
        @(negedge clk);
        check("in_ready_after_4", in_ready, 1);
        push(8'd200, 8'd13, 8'd15, 8'd5,  1'b0);
        @(negedge clk);
        check("in_ready_full", in_ready, 0);
        repeat (5) @(negedge clk);
        check("in_ready_still_full", in_ready, 0);
        check("held_results", exp_q.size(), 5);
        out_ready = 1'b1;
        push(8'd77, 8'd1, 8'd77, 8'd0, 1'b0);
        wait_drain("fifo_drain", 500);
        check("jobs_done_9", jobs_done, 9);
        check("in_ready_drained", in_ready, 1);

        // Reset while a job is stuck in WAIT with another queued
        hang = 1'b1;
        push(8'd20, 8'd3, 8'd6, 8'd2, 1'b0);
        push(8'd30, 8'd4, 8'd7, 8'd2, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        hang = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_div_start", div_start, 0);
        check("mid_rst_out_err", out_err, 0);
        check("mid_rst_out_qr", {out_q, out_r}, 0);
        check("mid_rst_div_ab", {div_a, div_b}, 0);
        check("mid_rst_jobs_done", jobs_done, 0);
        check("mid_rst_in_ready", in_ready, 1);
        s0 = n_start;
        repeat (100) @(negedge clk);
        check("mid_rst_fifo_empty", n_start - s0, 0);
        check("mid_rst_no_stale", jobs_done, 0);

        // jobs_done wrap
        @(negedge clk);
        force dut.r_jobs_done = 16'hFFFF;
        @(negedge clk);
        release dut.r_jobs_done;
        check("jobs_done_preload", jobs_done, 16'hFFFF);
        lat = 1;
        push(8'd14, 8'd3, 8'd4, 8'd2, 1'b0);
        wait_drain("wrap_drain", 100);
        check("jobs_done_wrap", jobs_done, 16'h0000);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_job_sequencer.md
Name: div_job_sequencer

Overview:
- Upstream and downstream wrapper stage for the 8-bit divider unit.
- Buffers operand pairs from a producer and issues them to the divider one at a time, driving a, b and start.
- Waits for the divider's ready, then captures q and r and presents the result on a valid/ready output channel.
- Handles divide-by-zero locally and applies a completion timeout so a stalled divider cannot hang the pipeline.

Parameters:
- WIDTH, 8, operand and result width. Must match the divider.
- DEPTH, 4, job FIFO entries. Must be a power of two and at least 2.
- TIMEOUT, 64, maximum cycles spent in WAIT before the job is aborted with an error.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer presents a job.
- in_ready  out  1  FIFO can accept a job; equals not-full.
- in_a  in  WIDTH  dividend.
- in_b  in  WIDTH  divisor.
- div_a  out  WIDTH  dividend to the divider.
- div_b  out  WIDTH  divisor to the divider.
- div_start  out  1  start pulse to the divider.
- div_busy  in  1  divider busy.
- div_ready  in  1  divider result ready.
- div_q  in  WIDTH  divider quotient.
- div_r  in  WIDTH  divider remainder.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_q  out  WIDTH  quotient.
- out_r  out  WIDTH  remainder.
- out_err  out  1  set on divide-by-zero or timeout.
- jobs_done  out  16  count of results accepted by the consumer; wraps at 2^16.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied.
  - State = IDLE.
  - div_start=0, out_valid=0, out_err=0; div_a, div_b, out_q, out_r = 0; jobs_done=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-job drops the job in flight and everything in the FIFO; no result is produced for them.
- Input handshake:
  - Push when in_valid && in_ready.
  - Push while full is impossible because in_ready=0.
  - Simultaneous push and pop on a full FIFO is not allowed; in_ready is computed from the registered count only.
- State machine:
  - IDLE: if FIFO not empty, pop the head and latch it into div_a/div_b.
    - If in_b==0: go to HOLD with out_q = all-ones, out_r = dividend, out_err=1. The divider is not started.
    - Otherwise go to ISSUE.
  - ISSUE: div_start=1 for exactly this one cycle; go to WAIT with the timeout counter cleared.
  - WAIT: div_start=0; div_a/div_b held stable.
    - On div_ready=1 && div_busy=0: capture div_q/div_r into out_q/out_r, out_err=0, go to HOLD.
    - Else, if the counter reaches TIMEOUT-1: out_q=0, out_r=0, out_err=1, go to HOLD.
    - div_ready is sampled no earlier than the cycle after ISSUE.
  - HOLD: out_valid=1, with out_q/out_r/out_err stable until out_ready.
    - On out_valid && out_ready: out_valid=0 next cycle, jobs_done+1, go to IDLE.
- Latency:
  - Empty FIFO to div_start = 2 cycles after the push edge (push, IDLE pop, ISSUE).
  - Divider ready to out_valid = 1 cycle.
  - Back-to-back jobs: minimum 1 idle cycle between a result being accepted and the next div_start.
- Ordering: results leave in exactly input order, including error results.
- Widths: the timeout counter is clog2(TIMEOUT) bits and saturates, never wraps.

Decomposition:
- Shared package div_pkg:
  - state enum {IDLE, ISSUE, WAIT, HOLD}
  - WIDTH default
  - DIV0_Q constant (all-ones)
  - TIMEOUT default
- Sub-module sync_fifo (parameters WIDTH*2 data, DEPTH):
  - push, pop, full, empty, count.
  - Synchronous reset.
  - Pointers wrap modulo DEPTH; count is one bit wider than the pointers.

Test Plan:
- Single job: a=14, b=3; divider model returns ready 4 cycles after start -> exactly one div_start pulse, then out_q=4, out_r=2, out_err=0, jobs_done=1.
- Divide-by-zero: a=9, b=0 -> div_start never asserts, out_q=0xFF, out_r=9, out_err=1.
- Timeout: divider model never asserts ready, TIMEOUT=64 -> out_valid rises 64 cycles after WAIT is entered, with out_err=1 and out_q=out_r=0.
- FIFO full and backpressure: push 6 jobs with out_ready=0 -> in_ready drops after 5 accepted (4 in the FIFO plus 1 in flight). Then release out_ready -> all results arrive in order (100/7=14 r2, 255/16=15 r15, 0/5=0 r0, ...).
- Reset mid-WAIT: assert rst for 1 cycle -> all outputs return to reset values next cycle, FIFO empty, and no stale result appears afterwards.
- jobs_done wrap: preload the counter to 0xFFFF via force, complete one job -> jobs_done=0x0000.
